// File: rtl/cbs_tx_selector_pkg.sv
// Shared constants for the CBS transmission selector: FSM encoding,
// default queue count and a one-hot to index helper.
package cbs_tx_selector_pkg;

    localparam int STATE_W = 1;
    localparam logic [STATE_W-1:0] ST_IDLE = 1'b0;
    localparam logic [STATE_W-1:0] ST_XMIT = 1'b1;

    localparam int NUM_QUEUES_DEF = 4;
    // Widest grant vector onehot_to_index accepts.
    localparam int MAX_QUEUES = 32;

    // Index of the set bit in a one-hot vector; 0 when no bit is set.
    function automatic int onehot_to_index(input logic [MAX_QUEUES-1:0] oh);
        int idx;
        idx = 0;
        for (int i = 0; i < MAX_QUEUES; i++) begin
            if (oh[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/cbs_tx_selector_prio_enc.sv
// Fixed-priority encoder: one-hot of the highest-index request.
module cbs_tx_selector_prio_enc #(
    parameter int N = 4
) (
    input  logic [N-1:0] req_i,
    output logic [N-1:0] gnt_o,
    output logic         vld_o
);

    // Later (higher) indices overwrite earlier ones, so the top request wins.
    always_comb begin
        gnt_o = '0;
        for (int i = 0; i < N; i++) begin
            if (req_i[i]) begin
                gnt_o    = '0;
                gnt_o[i] = 1'b1;
            end
        end
        vld_o = |req_i;
    end

endmodule

// File: rtl/cbs_tx_selector.sv
// 802.1Qav transmission selection for one egress port: strict priority over
// eligible traffic classes, locked to a frame until its tlast handshake.
// Optional feature macro: CBS_TX_SELECTOR_FRAME_CNT_EN adds per-queue
// 32-bit sent-frame counters on port frame_cnt.
module cbs_tx_selector
    import cbs_tx_selector_pkg::*;
#(
    parameter int C_AXIS_TDATA_WIDTH = 8,
    parameter int C_AXIS_TKEEP_WIDTH = C_AXIS_TDATA_WIDTH / 8,
    parameter int NUM_QUEUES         = NUM_QUEUES_DEF
) (
    input  logic                                      clk,
    input  logic                                      rstn,
    input  logic [NUM_QUEUES-1:0]                     queue_eligible,
    input  logic [NUM_QUEUES*C_AXIS_TDATA_WIDTH-1:0]  s_axis_tdata,
    input  logic [NUM_QUEUES*C_AXIS_TKEEP_WIDTH-1:0]  s_axis_tkeep,
    input  logic [NUM_QUEUES-1:0]                     s_axis_tvalid,
    output logic [NUM_QUEUES-1:0]                     s_axis_tready,
    input  logic [NUM_QUEUES-1:0]                     s_axis_tlast,
    output logic [C_AXIS_TDATA_WIDTH-1:0]             m_axis_tdata,
    output logic [C_AXIS_TKEEP_WIDTH-1:0]             m_axis_tkeep,
    output logic                                      m_axis_tvalid,
    input  logic                                      m_axis_tready,
    output logic                                      m_axis_tlast,
    output logic [NUM_QUEUES-1:0]                     grant,
`ifdef CBS_TX_SELECTOR_FRAME_CNT_EN
    output logic [NUM_QUEUES*32-1:0]                  frame_cnt,
`endif
    output logic                                      busy
);

    localparam int W     = C_AXIS_TDATA_WIDTH;
    localparam int K     = C_AXIS_TKEEP_WIDTH;
    localparam int IDX_W = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1;

    logic [STATE_W-1:0]    state_q, state_d;
    logic [NUM_QUEUES-1:0] grant_q, grant_d;
    logic [NUM_QUEUES-1:0] cand, enc_gnt;
    logic                  enc_vld;
    logic [IDX_W-1:0]      g_idx;
    logic                  xmit;
    logic                  hs_last;

    // Eligibility only matters at arbitration time; mid-frame it is ignored.
    assign cand = s_axis_tvalid & queue_eligible;

    cbs_tx_selector_prio_enc #(.N(NUM_QUEUES)) u_prio_enc (
        .req_i (cand),
        .gnt_o (enc_gnt),
        .vld_o (enc_vld)
    );

    assign xmit  = (state_q == ST_XMIT);
    assign g_idx = IDX_W'(onehot_to_index(MAX_QUEUES'(grant_q)));

    // Zero-latency mux from the granted queue; everything is 0 when idle or
    // when the granted queue has no valid beat.
    always_comb begin
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tlast  = 1'b0;
        s_axis_tready = '0;
        if (xmit) begin
            m_axis_tvalid        = s_axis_tvalid[g_idx];
            s_axis_tready[g_idx] = m_axis_tready;
            if (s_axis_tvalid[g_idx]) begin
                m_axis_tdata = s_axis_tdata[g_idx*W +: W];
                m_axis_tkeep = s_axis_tkeep[g_idx*K +: K];
                m_axis_tlast = s_axis_tlast[g_idx];
            end
        end
    end

    assign hs_last = xmit & m_axis_tvalid & m_axis_tready & m_axis_tlast;

    // IDLE grabs the top candidate; XMIT holds the grant until the frame ends.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        case (state_q)
            ST_IDLE: begin
                if (enc_vld) begin
                    state_d = ST_XMIT;
                    grant_d = enc_gnt;
                end
            end
            default: begin
                if (hs_last) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                end
            end
        endcase
    end

    // FSM and grant registers; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
        end
    end

    assign grant = grant_q;
    assign busy  = xmit;

`ifdef CBS_TX_SELECTOR_FRAME_CNT_EN
    logic [NUM_QUEUES-1:0][31:0] cnt_q, cnt_d;

    // Count completed frames per queue; wraps naturally at 2^32.
    always_comb begin
        cnt_d = cnt_q;
        for (int q = 0; q < NUM_QUEUES; q++) begin
            if (hs_last && grant_q[q]) cnt_d[q] = cnt_q[q] + 32'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign frame_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_cbs_tx_selector.sv
// Scoreboard bench for cbs_tx_selector: per-queue frame lists feed the DUT,
// a behavioural arbiter model predicts which frame goes out next, and a
// separate monitor pops expected beats on every output handshake.
module tb_cbs_tx_selector;
    localparam int W  = 8;
    localparam int K  = 1;
    localparam int NQ = 4;
    localparam int BW = W + K + 1;   // {last, keep, data}

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic [NQ-1:0]   queue_eligible, s_axis_tvalid, s_axis_tready, s_axis_tlast, grant;
    logic [NQ*W-1:0] s_axis_tdata;
    logic [NQ*K-1:0] s_axis_tkeep;
    logic [W-1:0]    m_axis_tdata;
    logic [K-1:0]    m_axis_tkeep;
    logic            m_axis_tvalid, m_axis_tready, m_axis_tlast, busy;
`ifdef CBS_TX_SELECTOR_FRAME_CNT_EN
    logic [NQ*32-1:0] frame_cnt;
`endif

    cbs_tx_selector #(
        .C_AXIS_TDATA_WIDTH (W),
        .C_AXIS_TKEEP_WIDTH (K),
        .NUM_QUEUES         (NQ)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .queue_eligible (queue_eligible),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tkeep   (s_axis_tkeep),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .s_axis_tlast   (s_axis_tlast),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tkeep   (m_axis_tkeep),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .m_axis_tlast   (m_axis_tlast),
        .grant          (grant),
`ifdef CBS_TX_SELECTOR_FRAME_CNT_EN
        .frame_cnt      (frame_cnt),
`endif
        .busy           (busy)
    );

    // Pending beats per queue and expected output beats.
    logic [BW-1:0] bq[NQ][$];
    logic [BW-1:0] expq[$];
    bit            m_busy;
    int            m_owner;
    int unsigned   m_cnt[NQ];
    int            total = 0;
    int            bad   = 0;
    bit            gap_en, rdy_rnd, elig_rnd;
    logic [NQ-1:0] elig_fix;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic add_frame(input int q, input int len);
        for (int i = 0; i < len; i++)
            bq[q].push_back({(i == len - 1), K'($urandom), W'($urandom)});
    endtask

    // Present inputs for this cycle (called on the falling edge).
    task automatic drive();
        logic [BW-1:0] b;
        for (int q = 0; q < NQ; q++) begin
            if (bq[q].size() > 0 && !(gap_en && $urandom_range(0, 3) == 0)) begin
                b = bq[q][0];
                s_axis_tvalid[q]        = 1'b1;
                s_axis_tdata[q*W +: W]  = b[W-1:0];
                s_axis_tkeep[q*K +: K]  = b[W +: K];
                s_axis_tlast[q]         = b[BW-1];
            end else begin
                // Garbage on idle lanes must never leak to the output.
                s_axis_tvalid[q]        = 1'b0;
                s_axis_tdata[q*W +: W]  = W'($urandom);
                s_axis_tkeep[q*K +: K]  = K'($urandom);
                s_axis_tlast[q]         = 1'($urandom);
            end
            queue_eligible[q] = elig_rnd ? ($urandom_range(0, 3) != 0) : elig_fix[q];
        end
        m_axis_tready = rdy_rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    // Reference arbiter: strict priority among valid+eligible queues when
    // free; a chosen frame is emitted whole, in order, before anything else.
    task automatic model();
        logic [NQ-1:0] cand;
        logic [BW-1:0] b;
        int            g;
        if (!rstn) begin
            m_busy = 0;
            expq.delete();
            for (int q = 0; q < NQ; q++) m_cnt[q] = 0;
        end else if (!m_busy) begin
            cand = s_axis_tvalid & queue_eligible;
            if (cand != '0) begin
                g = 0;
                for (int q = 0; q < NQ; q++) if (cand[q]) g = q;
                m_busy  = 1;
                m_owner = g;
                for (int i = 0; i < bq[g].size(); i++) begin
                    expq.push_back(bq[g][i]);
                    if (bq[g][i][BW-1]) break;
                end
            end
        end else if (s_axis_tvalid[m_owner] && m_axis_tready) begin
            b = bq[m_owner].pop_front();
            if (b[BW-1]) begin
                m_busy = 0;
                m_cnt[m_owner]++;
            end
        end
    endtask

    task automatic step(input bit rst_low);
        @(negedge clk);
        rstn = !rst_low;
        drive();
        #2;
        model();
    endtask

    function automatic bit pending();
        bit p;
        p = m_busy;
        for (int q = 0; q < NQ; q++) if (bq[q].size() > 0) p = 1;
        return p;
    endfunction

    task automatic run_until_idle(input int budget);
        int n;
        n = 0;
        do begin
            step(0);
            n++;
        end while (pending() && n < budget);
        if (pending()) begin
            total++;
            bad++;
            $display("FAIL drain_timeout got=pending want=idle after %0d cycles", n);
        end
        repeat (2) step(0);
    endtask

    // Monitor: compares DUT outputs against model state and expected beats.
    always @(negedge clk) begin
        logic [NQ-1:0] eg, er;
        logic          ev;
        logic [BW-1:0] b;
        #1;
        if (!rstn) begin
            chk("rst_grant", grant, 0);
            chk("rst_busy", busy, 0);
            chk("rst_sready", s_axis_tready, 0);
            chk("rst_mvalid", m_axis_tvalid, 0);
            chk("rst_mbeat", {m_axis_tlast, m_axis_tkeep, m_axis_tdata}, 0);
`ifdef CBS_TX_SELECTOR_FRAME_CNT_EN
            chk("rst_frame_cnt", frame_cnt != '0, 0);
`endif
        end else begin
            eg = '0; er = '0; ev = 1'b0;
            if (m_busy) begin
                eg[m_owner] = 1'b1;
                er[m_owner] = m_axis_tready;
                ev          = s_axis_tvalid[m_owner];
            end
            chk("grant", grant, eg);
            chk("busy", busy, m_busy);
            chk("sready", s_axis_tready, er);
            chk("mvalid", m_axis_tvalid, ev);
            if (m_axis_tvalid && m_axis_tready) begin
                if (expq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL beat got=%0h want=none", {m_axis_tlast, m_axis_tkeep, m_axis_tdata});
                end else begin
                    b = expq.pop_front();
                    chk("beat", {m_axis_tlast, m_axis_tkeep, m_axis_tdata}, b);
                end
            end else if (!m_axis_tvalid) begin
                chk("idle_zero", {m_axis_tlast, m_axis_tkeep, m_axis_tdata}, 0);
            end
`ifdef CBS_TX_SELECTOR_FRAME_CNT_EN
            for (int q = 0; q < NQ; q++) chk("frame_cnt", frame_cnt[q*32 +: 32], m_cnt[q]);
`endif
        end
    end

    initial begin
        rstn = 1'b0;
        queue_eligible = '0; s_axis_tvalid = '0; s_axis_tdata = '0;
        s_axis_tkeep = '0; s_axis_tlast = '0; m_axis_tready = 1'b0;
        gap_en = 0; rdy_rnd = 0; elig_rnd = 0; elig_fix = '1;
        m_busy = 0; m_owner = 0;
        for (int q = 0; q < NQ; q++) m_cnt[q] = 0;
        repeat (3) step(1);

        // Single queue, 64-beat frame.
        add_frame(0, 64);
        run_until_idle(200);

        // Two queues valid together: q3 first, then q1.
        add_frame(1, 5);
        add_frame(3, 7);
        run_until_idle(100);

        // q3 ineligible so q0 goes; q3 becomes eligible mid-frame and waits.
        elig_fix = 4'b0001;
        add_frame(3, 6);
        add_frame(0, 20);
        repeat (8) step(0);
        elig_fix = 4'b1111;
        run_until_idle(100);

        // Granted queue loses eligibility at beat 10; frame still completes.
        add_frame(2, 16);
        repeat (11) step(0);
        elig_fix = 4'b1011;
        run_until_idle(100);
        elig_fix = 4'b1111;

        // Random traffic, ready, valid gaps and eligibility.
        gap_en = 1; rdy_rnd = 1; elig_rnd = 1;
        repeat (10) begin
            repeat (4) add_frame($urandom_range(0, NQ - 1), $urandom_range(1, 12));
            run_until_idle(3000);
        end
        gap_en = 0; rdy_rnd = 0; elig_rnd = 0;

        // Reset mid-frame, then the remainder arbitrates as a fresh frame.
        add_frame(1, 30);
        repeat (10) step(0);
        repeat (2) step(1);
        add_frame(2, 4);
        run_until_idle(200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
